// File: rtl/audio_pkg.sv
// Shared sample width, saturation limits, FSM encodings and saturating add
// for the audio mix arbiter.
package audio_pkg;

   localparam int SAMPLE_W = 32;

   localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 32'sh7FFF_FFFF;
   localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 32'sh8000_0000;

   localparam logic [0:0] SFX_IDLE   = 1'b0;
   localparam logic [0:0] SFX_PLAY   = 1'b1;
   localparam logic [0:0] PACE_READY = 1'b0;
   localparam logic [0:0] PACE_GAP   = 1'b1;

   // Overflow shows up as disagreement between the two top bits of the 33-bit sum.
   function automatic logic signed [SAMPLE_W-1:0] sat_add(
      input logic signed [SAMPLE_W-1:0] a,
      input logic signed [SAMPLE_W-1:0] b
   );
      logic signed [SAMPLE_W:0] s;
      s = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
      if (s[SAMPLE_W] != s[SAMPLE_W-1])
         return s[SAMPLE_W] ? SAT_MIN : SAT_MAX;
      return s[SAMPLE_W-1:0];
   endfunction

endpackage

// File: rtl/audio_mix_arbiter_sfx_square_voice.sv
// One-shot square-wave SFX voice with a one-deep pending request slot;
// emits the signed sample, a busy flag and a pulse for each dropped request.
module sfx_square_voice
   import audio_pkg::*;
#(
   parameter logic signed [SAMPLE_W-1:0] SFX_AMPL = 32'sd100000000
) (
   input  logic                CLOCK_50,
   input  logic                reset,
   input  logic                sfx_req,
   input  logic [31:0]         sfx_half_period,
   input  logic [31:0]         sfx_duration,
   output logic [SAMPLE_W-1:0] sfx_sample,
   output logic                sfx_busy,
   output logic                sfx_drop
);

   logic [0:0]  state;
   logic        pend_vld;
   logic [31:0] pend_hp;
   logic [31:0] pend_dur;
   logic [31:0] hp;
   logic [31:0] dur;
   logic [31:0] dur_cnt;
   logic [31:0] per_cnt;
   logic        pol;

   logic        req_ok;
   logic [31:0] req_hp;
   logic        play_end;

   // Zero-length requests never start or queue anything.
   assign req_ok   = sfx_req && (sfx_duration != 32'd0);
   assign req_hp   = (sfx_half_period == 32'd0) ? 32'd1 : sfx_half_period;
   assign play_end = (state == SFX_PLAY) && (dur_cnt == dur - 32'd1);
   assign sfx_drop = (state == SFX_PLAY) && !play_end && req_ok && pend_vld;

   assign sfx_busy   = (state == SFX_PLAY);
   assign sfx_sample = (state == SFX_PLAY) ? (pol ? SFX_AMPL : -SFX_AMPL) : '0;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state    <= SFX_IDLE;
         pend_vld <= 1'b0;
         pend_hp  <= 32'd0;
         pend_dur <= 32'd0;
         hp       <= 32'd0;
         dur      <= 32'd0;
         dur_cnt  <= 32'd0;
         per_cnt  <= 32'd0;
         pol      <= 1'b1;
      end else if (state == SFX_IDLE) begin
         if (req_ok) begin
            state   <= SFX_PLAY;
            hp      <= req_hp;
            dur     <= sfx_duration;
            dur_cnt <= 32'd0;
            per_cnt <= 32'd0;
            pol     <= 1'b1;
         end
      end else if (play_end) begin
         // Back-to-back: pending request first, a same-cycle request refills the slot.
         if (pend_vld) begin
            hp       <= pend_hp;
            dur      <= pend_dur;
            dur_cnt  <= 32'd0;
            per_cnt  <= 32'd0;
            pol      <= 1'b1;
            pend_vld <= req_ok;
            if (req_ok) begin
               pend_hp  <= req_hp;
               pend_dur <= sfx_duration;
            end
         end else if (req_ok) begin
            hp      <= req_hp;
            dur     <= sfx_duration;
            dur_cnt <= 32'd0;
            per_cnt <= 32'd0;
            pol     <= 1'b1;
         end else begin
            state <= SFX_IDLE;
         end
      end else begin
         dur_cnt <= dur_cnt + 32'd1;
         if (per_cnt == hp - 32'd1) begin
            per_cnt <= 32'd0;
            pol     <= ~pol;
         end else begin
            per_cnt <= per_cnt + 32'd1;
         end
         if (req_ok && !pend_vld) begin
            pend_vld <= 1'b1;
            pend_hp  <= req_hp;
            pend_dur <= sfx_duration;
         end
      end
   end

endmodule

// File: rtl/audio_mix_arbiter.sv
// Mixes music with the SFX voice, saturates, and paces codec writes.
// Build option AUDIO_MIX_DUCK_EN: attenuate music by DUCK_SHIFT while SFX plays.
module audio_mix_arbiter
   import audio_pkg::*;
#(
   parameter logic signed [SAMPLE_W-1:0] SFX_AMPL   = 32'sd100000000,
   parameter int                         DUCK_SHIFT = 2,
   parameter int                         DROP_CNT_W = 8
) (
   input  logic                  CLOCK_50,
   input  logic                  reset,
   input  logic [31:0]           music_sample,
   input  logic                  music_active,
   input  logic                  sfx_req,
   input  logic [31:0]           sfx_half_period,
   input  logic [31:0]           sfx_duration,
   input  logic                  audio_out_allowed,
   output logic [31:0]           left_channel_audio_out,
   output logic [31:0]           right_channel_audio_out,
   output logic                  write_audio_out,
   output logic                  sfx_busy,
   output logic [DROP_CNT_W-1:0] sfx_drop_cnt
);

   logic [SAMPLE_W-1:0]        sfx_raw;
   logic signed [SAMPLE_W-1:0] sfx_s;
   logic                       sfx_drop;
   logic signed [SAMPLE_W-1:0] music_m;
   logic signed [SAMPLE_W-1:0] mix_p0;
   logic [0:0]                 pace_st;

   sfx_square_voice #(
      .SFX_AMPL (SFX_AMPL)
   ) u_voice (
      .CLOCK_50        (CLOCK_50),
      .reset           (reset),
      .sfx_req         (sfx_req),
      .sfx_half_period (sfx_half_period),
      .sfx_duration    (sfx_duration),
      .sfx_sample      (sfx_raw),
      .sfx_busy        (sfx_busy),
      .sfx_drop        (sfx_drop)
   );

   assign sfx_s = $signed(sfx_raw);

   always_comb begin
      music_m = music_active ? $signed(music_sample) : '0;
`ifdef AUDIO_MIX_DUCK_EN
      if (sfx_busy)
         music_m = music_m >>> DUCK_SHIFT;
`endif
   end

   assign mix_p0 = sat_add(music_m, sfx_s);

   // Stage p0 -> output register: at most one write every two cycles.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         pace_st                 <= PACE_READY;
         write_audio_out         <= 1'b0;
         left_channel_audio_out  <= 32'd0;
         right_channel_audio_out <= 32'd0;
      end else if (pace_st == PACE_GAP) begin
         pace_st         <= PACE_READY;
         write_audio_out <= 1'b0;
      end else if (audio_out_allowed) begin
         pace_st                 <= PACE_GAP;
         write_audio_out         <= 1'b1;
         left_channel_audio_out  <= mix_p0;
         right_channel_audio_out <= mix_p0;
      end else begin
         write_audio_out <= 1'b0;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset)
         sfx_drop_cnt <= '0;
      else if (sfx_drop && (sfx_drop_cnt != {DROP_CNT_W{1'b1}}))
         sfx_drop_cnt <= sfx_drop_cnt + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
   end

endmodule

// File: tb/tb_audio_mix_arbiter.sv
// Self-checking bench for audio_mix_arbiter: vector table, directed sequences,
// and randomized traffic against a time-based reference model.
module tb_audio_mix_arbiter;

   localparam longint AMPL = 100000000;

   logic        CLOCK_50 = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] music_sample = 32'd0;
   logic        music_active = 1'b0;
   logic        sfx_req = 1'b0;
   logic [31:0] sfx_half_period = 32'd0;
   logic [31:0] sfx_duration = 32'd0;
   logic        audio_out_allowed = 1'b0;
   logic [31:0] left_channel_audio_out;
   logic [31:0] right_channel_audio_out;
   logic        write_audio_out;
   logic        sfx_busy;
   logic [7:0]  sfx_drop_cnt;

   audio_mix_arbiter dut (
      .CLOCK_50                (CLOCK_50),
      .reset                   (reset),
      .music_sample            (music_sample),
      .music_active            (music_active),
      .sfx_req                 (sfx_req),
      .sfx_half_period         (sfx_half_period),
      .sfx_duration            (sfx_duration),
      .audio_out_allowed       (audio_out_allowed),
      .left_channel_audio_out  (left_channel_audio_out),
      .right_channel_audio_out (right_channel_audio_out),
      .write_audio_out         (write_audio_out),
      .sfx_busy                (sfx_busy),
      .sfx_drop_cnt            (sfx_drop_cnt)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int total = 0;
   int bad   = 0;

   // Reference model: a playback is (start cycle, half period, duration);
   // polarity follows from elapsed time, queued requests sit in a queue.
   typedef struct {
      int hp;
      int dur;
   } req_t;

   int          cyc = 0;
   bit          m_play = 0;
   int          m_start = 0;
   int          m_hp = 1;
   int          m_dur = 0;
   req_t        pend[$];
   int          m_drop = 0;
   bit          m_gap = 0;
   logic [31:0] m_out = 32'd0;
   bit          m_wr = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_update();
      longint sfx, mm, s;
      bit     rv;
      int     rhp;
      req_t   r;
      if (reset) begin
         m_play = 0; pend.delete(); m_drop = 0; m_gap = 0; m_out = 32'd0; m_wr = 0;
         cyc++;
         return;
      end
      sfx = 0;
      if (m_play)
         sfx = ((((cyc - m_start) / m_hp) % 2) == 0) ? AMPL : -AMPL;
      mm = music_active ? longint'($signed(music_sample)) : 0;
`ifdef AUDIO_MIX_DUCK_EN
      if (m_play) mm = mm >>> 2;
`endif
      s = mm + sfx;
      if (s > 64'sd2147483647)  s = 64'sd2147483647;
      if (s < -64'sd2147483648) s = -64'sd2147483648;
      if (m_gap) begin
         m_gap = 0; m_wr = 0;
      end else if (audio_out_allowed) begin
         m_gap = 1; m_wr = 1; m_out = s[31:0];
      end else begin
         m_wr = 0;
      end
      rv  = sfx_req && (sfx_duration != 32'd0);
      rhp = (sfx_half_period == 32'd0) ? 1 : int'(sfx_half_period);
      if (!m_play) begin
         if (rv) begin
            m_play = 1; m_start = cyc + 1; m_hp = rhp; m_dur = int'(sfx_duration);
         end
      end else if (cyc - m_start == m_dur - 1) begin
         if (pend.size() > 0) begin
            r = pend.pop_front();
            m_start = cyc + 1; m_hp = r.hp; m_dur = r.dur;
            if (rv) begin
               r.hp = rhp; r.dur = int'(sfx_duration); pend.push_back(r);
            end
         end else if (rv) begin
            m_start = cyc + 1; m_hp = rhp; m_dur = int'(sfx_duration);
         end else begin
            m_play = 0;
         end
      end else if (rv) begin
         if (pend.size() == 0) begin
            r.hp = rhp; r.dur = int'(sfx_duration); pend.push_back(r);
         end else if (m_drop < 255) begin
            m_drop++;
         end
      end
      cyc++;
   endtask

   task automatic step(input logic rst, input logic [31:0] mus, input logic act,
                       input logic req, input logic [31:0] hpi, input logic [31:0] duri,
                       input logic alw);
      reset = rst; music_sample = mus; music_active = act; sfx_req = req;
      sfx_half_period = hpi; sfx_duration = duri; audio_out_allowed = alw;
      model_update();
      @(posedge CLOCK_50);
      #1;
      check("model_wr",    {31'd0, write_audio_out}, {31'd0, m_wr});
      check("model_left",  left_channel_audio_out, m_out);
      check("model_right", right_channel_audio_out, m_out);
      check("model_busy",  {31'd0, sfx_busy}, {31'd0, m_play});
      check("model_drop",  {24'd0, sfx_drop_cnt}, m_drop);
   endtask

   typedef struct {
      logic        rst;
      logic [31:0] mus;
      logic        act;
      logic        req;
      logic [31:0] hp;
      logic [31:0] dur;
      logic        alw;
      logic        wr;
      logic [31:0] out;
      logic        busy;
   } vec_t;

   vec_t tbl[15];

`ifdef AUDIO_MIX_DUCK_EN
   localparam logic [31:0] E_POS_HI = 32'h25F5_E0FC;
   localparam logic [31:0] E_NEG_LO = 32'hDA0A_1F04;
   localparam logic [31:0] E_400P   = 32'h05F5_E164;
`else
   localparam logic [31:0] E_POS_HI = 32'h7FFF_FFFF;
   localparam logic [31:0] E_NEG_LO = 32'h8000_0000;
   localparam logic [31:0] E_400P   = 32'h05F5_E290;
`endif

   initial begin
      int          busy_cnt;
      logic [31:0] held;
      logic        done;

      tbl[0]  = '{1'b1, 32'h1234_5678, 1'b1, 1'b1, 32'd4, 32'd16, 1'b1, 1'b0, 32'h0, 1'b0};
      tbl[1]  = '{1'b1, 32'h1234_5678, 1'b1, 1'b1, 32'd4, 32'd16, 1'b1, 1'b0, 32'h0, 1'b0};
      tbl[2]  = '{1'b0, 32'h7FFF_FFF0, 1'b1, 1'b1, 32'd4, 32'd16, 1'b1, 1'b1, 32'h7FFF_FFF0, 1'b1};
      tbl[3]  = '{1'b0, 32'h7FFF_FFF0, 1'b1, 1'b0, 32'd0, 32'd0,  1'b1, 1'b0, 32'h7FFF_FFF0, 1'b1};
      tbl[4]  = '{1'b0, 32'h7FFF_FFF0, 1'b1, 1'b0, 32'd0, 32'd0,  1'b1, 1'b1, E_POS_HI, 1'b1};
      tbl[5]  = '{1'b0, 32'h7FFF_FFF0, 1'b1, 1'b0, 32'd0, 32'd0,  1'b1, 1'b0, E_POS_HI, 1'b1};
      tbl[6]  = '{1'b0, 32'h7FFF_FFF0, 1'b1, 1'b0, 32'd0, 32'd0,  1'b1, 1'b1, E_POS_HI, 1'b1};
      tbl[7]  = '{1'b0, 32'h7FFF_FFF0, 1'b1, 1'b0, 32'd0, 32'd0,  1'b1, 1'b0, E_POS_HI, 1'b1};
      tbl[8]  = '{1'b0, 32'h8000_0010, 1'b1, 1'b0, 32'd0, 32'd0,  1'b1, 1'b1, E_NEG_LO, 1'b1};
      tbl[9]  = '{1'b0, 32'h8000_0010, 1'b1, 1'b0, 32'd0, 32'd0,  1'b1, 1'b0, E_NEG_LO, 1'b1};
      tbl[10] = '{1'b0, 32'h8000_0010, 1'b0, 1'b0, 32'd0, 32'd0,  1'b1, 1'b1, 32'hFA0A_1F00, 1'b1};
      tbl[11] = '{1'b0, 32'h8000_0010, 1'b0, 1'b0, 32'd0, 32'd0,  1'b1, 1'b0, 32'hFA0A_1F00, 1'b1};
      tbl[12] = '{1'b0, 32'h8000_0010, 1'b0, 1'b0, 32'd0, 32'd0,  1'b1, 1'b1, 32'h05F5_E100, 1'b1};
      tbl[13] = '{1'b0, 32'd400,       1'b1, 1'b0, 32'd0, 32'd0,  1'b1, 1'b0, 32'h05F5_E100, 1'b1};
      tbl[14] = '{1'b0, 32'd400,       1'b1, 1'b0, 32'd0, 32'd0,  1'b1, 1'b1, E_400P, 1'b1};

      busy_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         step(tbl[i].rst, tbl[i].mus, tbl[i].act, tbl[i].req, tbl[i].hp, tbl[i].dur, tbl[i].alw);
         check($sformatf("vec%0d_wr", i),   {31'd0, write_audio_out}, {31'd0, tbl[i].wr});
         check($sformatf("vec%0d_left", i), left_channel_audio_out, tbl[i].out);
         check($sformatf("vec%0d_busy", i), {31'd0, sfx_busy}, {31'd0, tbl[i].busy});
         if (sfx_busy) busy_cnt++;
      end
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         step(1'b0, 32'd400, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
         if (sfx_busy) busy_cnt++;
         else done = 1'b1;
      end
      check("basic_busy_len", busy_cnt, 32'd16);

      // Music alone after the SFX finished: no ducking applies.
      step(1'b0, 32'd400, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
      step(1'b0, 32'd400, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
      check("idle_music", left_channel_audio_out, 32'd400);

      // Queueing: B plays, A queued, C dropped; B+A run with no gap.
      step(1'b0, 32'd0, 1'b0, 1'b1, 32'd3, 32'd16, 1'b1);
      busy_cnt = sfx_busy ? 1 : 0;
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
         if (sfx_busy) busy_cnt++;
      end
      step(1'b0, 32'd0, 1'b0, 1'b1, 32'd2, 32'd8, 1'b1);
      if (sfx_busy) busy_cnt++;
      step(1'b0, 32'd0, 1'b0, 1'b1, 32'd5, 32'd5, 1'b1);
      if (sfx_busy) busy_cnt++;
      check("queue_drop_cnt", {24'd0, sfx_drop_cnt}, 32'd1);
      done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
         if (sfx_busy) busy_cnt++;
         else done = 1'b1;
      end
      check("queue_busy_len", busy_cnt, 32'd24);

      // Backpressure: no writes while audio_out_allowed is low, outputs hold.
      held = left_channel_audio_out;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, $urandom, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
         check("hold_wr",   {31'd0, write_audio_out}, 32'd0);
         check("hold_left", left_channel_audio_out, held);
      end

      // Reset mid-play with the slot full: playback stops and nothing follows.
      step(1'b0, 32'd0, 1'b0, 1'b1, 32'd4, 32'd30, 1'b1);
      step(1'b0, 32'd0, 1'b0, 1'b1, 32'd4, 32'd10, 1'b1);
      check("pre_reset_busy", {31'd0, sfx_busy}, 32'd1);
      step(1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      check("rst_busy", {31'd0, sfx_busy}, 32'd0);
      check("rst_wr",   {31'd0, write_audio_out}, 32'd0);
      check("rst_left", left_channel_audio_out, 32'd0);
      for (int i = 0; i < 45; i++) begin
         step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
         check("post_rst_idle", {31'd0, sfx_busy}, 32'd0);
      end

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] mus;
         case ($urandom_range(0, 3))
            0: mus = 32'h7FFF_FF00 + $urandom_range(0, 255);
            1: mus = 32'h8000_0000 + $urandom_range(0, 255);
            default: mus = $urandom;
         endcase
         step(($urandom_range(0, 499) == 0), mus, ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 9) == 0), $urandom_range(0, 6), $urandom_range(0, 30),
              ($urandom_range(0, 3) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/audio_mix_arbiter.md
Name: audio_mix_arbiter

Overview:
- Shares the single codec output path (Audio_Controller left/right sample inputs and write strobe) between two requesters: the background-music tone generator and a one-shot sound-effect (SFX) engine.
- Contains the SFX square-wave voice, which has a one-deep pending slot.
- Mixes the music and SFX samples with saturation, optionally ducking the music while an SFX plays.
- Paces writes against audio_out_allowed.
- Sits between the game logic or music sequencer and Audio_Controller.

Parameters:
- SFX_AMPL, 100000000: SFX square-wave magnitude. The SFX sample is +SFX_AMPL or -SFX_AMPL (32-bit two's complement).
- DUCK_SHIFT, 2: arithmetic right shift applied to the music sample while the SFX is active (DUCK feature only).
- DROP_CNT_W, 8: width of the dropped-request counter.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous reset, active-high.
- music_sample  in  32  signed music sample, sampled every cycle.
- music_active  in  1  when 0, the music contribution is forced to 0.
- sfx_req  in  1  single-cycle SFX trigger.
- sfx_half_period  in  32  SFX half-period in clock cycles, captured with sfx_req.
- sfx_duration  in  32  SFX length in clock cycles, captured with sfx_req.
- audio_out_allowed  in  1  from Audio_Controller: output FIFO can accept a sample.
- left_channel_audio_out  out  32  mixed sample to the codec.
- right_channel_audio_out  out  32  identical to left_channel_audio_out.
- write_audio_out  out  1  one-cycle write strobe.
- sfx_busy  out  1  SFX voice is in the PLAY state.
- sfx_drop_cnt  out  DROP_CNT_W  count of discarded requests; saturates at all-ones.

Behaviour:
- Interface: one clock, CLOCK_50. The reset port is named reset and is synchronous, active-high.
- Reset values of all outputs and state:
  - left/right channel outputs = 0.
  - write_audio_out = 0.
  - sfx_busy = 0.
  - sfx_drop_cnt = 0.
  - SFX FSM in IDLE, pending slot empty, all counters 0, polarity register = positive.
- SFX FSM, states IDLE and PLAY:
  - IDLE, on sfx_req with sfx_duration != 0: capture half_period and duration, clear both counters, set polarity positive, go to PLAY next cycle. sfx_busy goes high one cycle after sfx_req.
  - IDLE, on sfx_req with sfx_duration == 0: ignore the request. It is not counted as dropped.
  - A captured half_period of 0 is treated as 1.
  - PLAY, each cycle: dur_cnt increments and per_cnt increments.
    - When per_cnt reaches half_period-1, per_cnt clears and polarity toggles.
    - SFX sample = polarity ? +SFX_AMPL : -SFX_AMPL.
  - PLAY exits when dur_cnt reaches duration-1, so PLAY lasts exactly duration cycles.
    - If the pending slot is full, load it and stay in PLAY with counters cleared and polarity positive. There is no idle gap.
    - Otherwise go to IDLE.
  - sfx_req while in PLAY: if the pending slot is empty, store the request. If it is full, the new request is dropped and sfx_drop_cnt increments (saturating). The stored request is kept.
  - sfx_req in the same cycle PLAY ends: the current pending request, if any, is loaded first. The new request then goes into the freed slot.
- SFX sample outside PLAY = 0.
- Mix path:
  - m = music_active ? music_sample : 0.
  - With DUCK_EN defined and PLAY active, m is replaced by m >>> DUCK_SHIFT.
  - Sum is m + sfx, computed in 33 bits and saturated to the range 0x8000_0000..0x7FFF_FFFF.
- Output handshake:
  - Two-state pacing FSM, READY and GAP.
  - READY, with audio_out_allowed high: register the mix into both channel outputs, assert write_audio_out for one cycle, go to GAP.
  - GAP lasts one cycle, then returns to READY.
  - Maximum rate is one write per 2 cycles, so a deassertion of audio_out_allowed is always observed.
  - Channel outputs change only on a write cycle and hold their value otherwise.
  - Latency: the mix is sampled in the cycle audio_out_allowed is seen, and data plus strobe are visible on the next edge.
- Reset mid-operation: playback aborts immediately, the pending slot is cleared, and all outputs take their reset values on the next edge.

Optional Feature:
- Macro: AUDIO_MIX_DUCK_EN.
- Defined: while sfx_busy is high, music is attenuated by the arithmetic shift DUCK_SHIFT before summing.
- Undefined: music is summed unattenuated. DUCK_SHIFT is unused, and no shifter is synthesized.

Decomposition:
- Shared package audio_pkg holds:
  - SAMPLE_W = 32.
  - SAT_MAX = 32'h7FFF_FFFF and SAT_MIN = 32'h8000_0000.
  - The SFX state encoding (IDLE, PLAY) and the pacing state encoding (READY, GAP).
  - A saturating-add function.
- One sub-module is natural: sfx_square_voice, containing the FSM, pending slot, counters and polarity, and outputting the signed sample, busy and drop pulse.
- Mixing and pacing stay in the top level.

Test Plan:
1. Reset: assert reset for 2 cycles with all inputs active → all outputs 0 on the first edge after reset; write_audio_out stays 0 during reset.
2. Basic SFX: half_period=4, duration=16, music_active=0, audio_out_allowed=1 → sfx_busy high for exactly 16 cycles; the SFX sample is +1e8 for 4 cycles, then -1e8 for 4, repeating; write strobes on alternate cycles carry the matching values.
3. Queueing: request A (duration 8) during PLAY of B → A follows B with zero idle cycles. A third request during B with the slot full → sfx_drop_cnt=1, and only B then A play.
4. Saturation: music_sample=0x7FFF_FFF0, SFX positive → output 0x7FFF_FFFF. music_sample=0x8000_0010, SFX negative → output 0x8000_0000.
5. Ducking (DUCK_EN built): music_sample=400, SFX idle → output 400. During SFX with DUCK_SHIFT=2 → output 100 ± SFX_AMPL. Non-DUCK build: 400 ± SFX_AMPL.
6. Handshake and reset: audio_out_allowed low for 10 cycles → no writes and outputs hold. Reset asserted mid-PLAY with the slot full → sfx_busy=0 and the slot empty next cycle; no further playback.
